// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped countdown timer.
// FSM states, mode codes, register offsets and CTRL bit positions.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ONE = 2'b00;
  localparam logic [1:0] MODE_PER = 2'b01;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IM = 3;

endpackage

// File: rtl/timer_regs.sv
// Bus decode, CTRL/PRESET registers and read mux for timer_counter.
// TIMER_IRQ_EN keeps the CTRL.IM bit; otherwise it reads 0.
module timer_regs
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] count,
  input  logic        en_clr,
  output logic        en,
  output logic [1:0]  mode,
`ifdef TIMER_IRQ_EN
  output logic        im,
  output logic        ctrl_wr,
`endif
  output logic [31:0] preset,
  output logic [31:0] rdata
);

`ifdef TIMER_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

  logic [3:0] ctrl_q;
  logic       wr_ctrl;
  logic       wr_pre;
  logic       unused_wdata;

  assign wr_ctrl      = we && (sel == OFF_CTRL);
  assign wr_pre       = we && (sel == OFF_PRESET);
  assign unused_wdata = ^wdata[31:3];

  // CTRL: a bus write beats the FSM's En-clear on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q <= wdata[3:0] & CTRL_MASK;
    end else if (en_clr) begin
      ctrl_q[CTRL_EN] <= 1'b0;
    end
  end

  // PRESET is only sampled by the FSM in LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= '0;
    end else if (wr_pre) begin
      preset <= wdata;
    end
  end

  // Combinational read mux on the word offset
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (sel == OFF_CTRL):   rdata = {28'd0, ctrl_q};
      (sel == OFF_PRESET): rdata = preset;
      (sel == OFF_COUNT):  rdata = count;
      (sel == OFF_RSVD):   rdata = '0;
    endcase
  end

  assign en   = ctrl_q[CTRL_EN];
  assign mode = ctrl_q[2:1];
`ifdef TIMER_IRQ_EN
  assign im      = ctrl_q[CTRL_IM];
  assign ctrl_wr = wr_ctrl;
`endif

endmodule

// File: rtl/timer_counter.sv
// Countdown timer with one-shot and periodic reload, level irq to CP0.
// Define TIMER_IRQ_EN to build the pending/IM interrupt logic.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic [31:0] preset;
  logic        en;
  logic        en_clr;
  logic [1:0]  mode;
  logic        periodic;
  logic        unused_addr;

  assign unused_addr = ^{addr[31:4], addr[1:0]};
  assign periodic    = (mode == MODE_PER);

`ifdef TIMER_IRQ_EN
  logic im;
  logic ctrl_wr;
  logic pending;
`endif

  timer_regs u_regs (
    .clk     (clk),
    .reset   (reset),
    .sel     (addr[3:2]),
    .we      (we),
    .wdata   (wdata),
    .count   (count),
    .en_clr  (en_clr),
    .en      (en),
    .mode    (mode),
`ifdef TIMER_IRQ_EN
    .im      (im),
    .ctrl_wr (ctrl_wr),
`endif
    .preset  (preset),
    .rdata   (rdata)
  );

  // State and COUNT registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next state; COUNT saturates at 0 and PRESET=0 acts like 1
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    en_clr    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count <= 32'd1) begin
          count_nxt = '0;
          state_nxt = ST_INT;
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      ST_INT: begin
        if (periodic) begin
          state_nxt = ST_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

`ifdef TIMER_IRQ_EN
  // pending sets on entry to INT; only a CTRL write drops it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (state == ST_CNT && state_nxt == ST_INT) begin
      pending <= 1'b1;
    end else if (ctrl_wr) begin
      pending <= 1'b0;
    end
  end

  assign irq = pending & im;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: vector table, directed
// corner sequences and randomized traffic against a reference model.
module tb_timer_counter;

`ifdef TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [31:0] CMASK = IRQ_ON ? 32'hF : 32'h7;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl[$];

  // reference model: timer phase 0 idle, 1 reload, 2 counting, 3 expired
  int          m_ph;
  logic [3:0]  m_ctrl;
  logic [31:0] m_pre;
  logic [31:0] m_cnt;
  bit          m_pend;

  task automatic model_reset();
    m_ph = 0; m_ctrl = '0; m_pre = '0; m_cnt = '0; m_pend = 0;
  endtask

  task automatic model_step(input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    bit en  = m_ctrl[0];
    bit per = (m_ctrl[2:1] == 2'b01);
    bit hit = 0;
    bit drop = 0;
    bit cw  = w && (a[3:2] == 2'd0);
    int ph  = m_ph;
    case (m_ph)
      0: if (en) ph = 1;
      1: begin m_cnt = m_pre; ph = 2; end
      2: begin
        if (!en) ph = 0;
        else if (m_cnt <= 1) begin m_cnt = 0; hit = 1; ph = 3; end
        else m_cnt = m_cnt - 1;
      end
      default: begin
        if (per) ph = 1;
        else begin drop = 1; ph = 0; end
      end
    endcase
    m_ph = ph;
    if (cw) m_ctrl = d[3:0] & CMASK[3:0];
    else if (drop) m_ctrl[0] = 1'b0;
    if (w && a[3:2] == 2'd1) m_pre = d;
    if (hit) m_pend = 1;
    else if (cw) m_pend = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    case (a[3:2])
      2'd0: return {28'd0, m_ctrl};
      2'd1: return m_pre;
      2'd2: return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    we = w; addr = a; wdata = d;
    @(posedge clk);
    model_step(w, a, d);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    tick(1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    tick(1'b0, a, 32'd0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic add(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] r,
                     input logic i);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.rd = r; v.irq = i;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_rd;
    logic [31:0] per_seq[11];
    reset = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #12;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) reset = 1'b1;

    // asynchronous reset in the middle of a count
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    for (int e = 1; e <= 5; e++) rd(32'h8);
    chk("pre_reset_count", rdata, 32'd7);
    do_reset();
    chk("async_reset_count", rdata, 32'd0);
    chk("async_reset_irq", {31'd0, irq}, 32'd0);
    addr = 32'h0; #1;
    chk("async_reset_ctrl", rdata, 32'd0);
    addr = 32'h4; #1;
    chk("async_reset_preset", rdata, 32'd0);
    @(negedge clk) reset = 1'b1;
    for (int e = 0; e < 3; e++) begin
      rd(32'h8);
      chk("post_reset_idle", rdata, 32'd0);
    end

    // one-shot with IM, as a vector table
    add(1, 32'h4, 32'd5, 32'd5, 0);
    add(1, 32'h0, 32'h9, 32'h9, 0);
    add(0, 32'h8, 0, 32'd0, 0);
    add(0, 32'h8, 0, 32'd5, 0);
    add(0, 32'h8, 0, 32'd4, 0);
    add(0, 32'h8, 0, 32'd3, 0);
    add(0, 32'h8, 0, 32'd2, 0);
    add(0, 32'h8, 0, 32'd1, 0);
    add(0, 32'h8, 0, 32'd0, 1);
    add(0, 32'h0, 0, 32'h8, 1);
    add(0, 32'h8, 0, 32'd0, 1);
    add(1, 32'h0, 0, 32'h0, 0);
    add(0, 32'h4, 0, 32'd5, 0);
    foreach (tbl[i]) begin
      tick(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      exp_rd = tbl[i].rd;
      if (tbl[i].addr[3:2] == 2'd0) exp_rd = exp_rd & CMASK;
      chk($sformatf("vec%0d_rdata", i), rdata, exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq},
          {31'd0, tbl[i].irq & IRQ_ON});
    end

    // periodic reload, period N+2
    per_seq = '{3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int e = 1; e <= 12; e++) begin
      rd(32'h8);
      if (e >= 2) chk($sformatf("per_e%0d", e), rdata, per_seq[e-2]);
      chk($sformatf("per_irq_e%0d", e), {31'd0, irq},
          {31'd0, (e >= 5) & IRQ_ON});
    end
    wr(32'h0, 32'h0);
    rd(32'h8); rd(32'h8);
    chk("per_stop_irq", {31'd0, irq}, 32'd0);

    // pause and re-enable
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    for (int e = 1; e <= 6; e++) rd(32'h8);
    chk("pause_at6", rdata, 32'd6);
    wr(32'h0, 32'h8);
    for (int e = 0; e < 3; e++) begin
      rd(32'h8);
      chk("pause_hold", rdata, 32'd5);
      chk("pause_irq", {31'd0, irq}, 32'd0);
    end
    wr(32'h0, 32'h9);
    rd(32'h8); rd(32'h8);
    chk("pause_reload", rdata, 32'd10);
    wr(32'h0, 32'h0);
    rd(32'h8); rd(32'h8);

    // PRESET=0 behaves like 1
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    rd(32'h8); rd(32'h8);
    chk("p0_e2_irq", {31'd0, irq}, 32'd0);
    rd(32'h8);
    chk("p0_e3_irq", {31'd0, irq}, {31'd0, IRQ_ON});
    rd(32'h0);
    chk("p0_ctrl", rdata, 32'h8 & CMASK);
    wr(32'h0, 32'h0);
    chk("p0_clear", {31'd0, irq}, 32'd0);

    // PRESET write during CNT lands at next reload
    wr(32'h4, 32'd4);
    wr(32'h0, 32'hB);
    rd(32'h8); rd(32'h8);
    chk("pw_e2", rdata, 32'd4);
    wr(32'h4, 32'd9);
    rd(32'h8); chk("pw_e4", rdata, 32'd2);
    rd(32'h8); chk("pw_e5", rdata, 32'd1);
    rd(32'h8); chk("pw_e6", rdata, 32'd0);
    rd(32'h8); chk("pw_e7", rdata, 32'd0);
    rd(32'h8); chk("pw_e8", rdata, 32'd9);
    wr(32'h0, 32'h0);
    rd(32'h8); rd(32'h8);

    // bus write of En=1 collides with one-shot En-clear
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    for (int e = 1; e <= 4; e++) rd(32'h8);
    chk("col_e4_count", rdata, 32'd0);
    chk("col_e4_irq", {31'd0, irq}, {31'd0, IRQ_ON});
    wr(32'h0, 32'h9);
    chk("col_ctrl", rdata, 32'h9 & CMASK);
    chk("col_irq", {31'd0, irq}, 32'd0);
    rd(32'h8); rd(32'h8);
    chk("col_restart", rdata, 32'd2);
    wr(32'h8, 32'h55);
    chk("count_ro", rdata, 32'd1);
    wr(32'hC, 32'hFFFF_FFFF);
    chk("rsvd_read", rdata, 32'd0);
    rd(32'h4);
    chk("rsvd_preset", rdata, 32'd2);
    rd(32'h0);
    chk("rsvd_ctrl", rdata, 32'h8 & CMASK);
    wr(32'h0, 32'h0);

    // randomized traffic against the model
    do_reset();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        chk("rnd_reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk) reset = 1'b1;
      end
      a = $urandom;
      w = ($urandom_range(0, 5) == 0);
      d = (a[3:2] == 2'd1) ? $urandom_range(0, 12) : $urandom;
      tick(w, a, d);
      chk("rnd_rdata", rdata, model_rd(a));
      chk("rnd_irq", {31'd0, irq},
          {31'd0, m_pend & m_ctrl[3] & IRQ_ON});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
